// File: rtl/aes128_dsp_keyfeed.sv
// Round-key sequencer for the interleaved aes128_dsp core: captures a cipher key on go,
// then presents K, SK1..SK10, each held for INTERLEAVE cycles, expanding keys on the fly.
module aes128_dsp_keyfeed #(
    parameter int INTERLEAVE = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [127:0] key_in,
    output logic [127:0] key_out,
    output logic         key_valid,
    output logic [3:0]   round,
    output logic         last,
    output logic         busy
);

    localparam int SW = (INTERLEAVE > 1) ? $clog2(INTERLEAVE) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(INTERLEAVE - 1);

    // AES S-box, entry 0 in the most significant byte
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state;
    logic [SW-1:0]   slot;
    logic [7:0]      rcon;
    logic [127:0]    next_key;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] rot;
        logic [31:0] t;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] n3;
        rot = {k[23:0], k[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {rc, 24'h0};
        n0  = k[127:96] ^ t;
        n1  = k[95:64]  ^ n0;
        n2  = k[63:32]  ^ n1;
        n3  = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    always_comb begin
        next_key = expand(key_out, rcon);
    end

    // rcon always holds the constant for the next key to be produced
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            slot      <= '0;
            rcon      <= 8'h00;
            key_out   <= '0;
            key_valid <= 1'b0;
            round     <= 4'd0;
            last      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state     <= RUN;
                        slot      <= '0;
                        rcon      <= 8'h01;
                        key_out   <= key_in;
                        key_valid <= 1'b1;
                        round     <= 4'd0;
                        last      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (slot == SLOT_LAST) begin
                        if (round == 4'd10) begin
                            state     <= IDLE;
                            slot      <= '0;
                            rcon      <= 8'h00;
                            key_out   <= '0;
                            key_valid <= 1'b0;
                            round     <= 4'd0;
                            last      <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            slot    <= '0;
                            rcon    <= xtime(rcon);
                            key_out <= next_key;
                            round   <= round + 4'd1;
                            last    <= (round == 4'd9);
                        end
                    end else begin
                        slot <= slot + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_dsp_keyfeed.sv
// Directed bench for aes128_dsp_keyfeed: table-driven key schedules on the default build
// plus busy-GO, mid-run reset and INTERLEAVE=1 sequences.
module tb_aes128_dsp_keyfeed;

    localparam int IL = 8;

    typedef struct {
        logic [127:0]         key;
        logic [10:0][127:0]   rk;
    } sched_t;

    logic         clk;
    logic         rst;
    logic         go;
    logic [127:0] key_in;
    logic [127:0] key_out;
    logic         key_valid;
    logic [3:0]   round;
    logic         last;
    logic         busy;

    logic         go1;
    logic [127:0] key_in1;
    logic [127:0] key_out1;
    logic         key_valid1;
    logic [3:0]   round1;
    logic         last1;
    logic         busy1;

    int total;
    int bad;

    sched_t vec [2];
    logic [10:0][127:0] ones_rk;

    aes128_dsp_keyfeed #(.INTERLEAVE(IL)) dut (
        .clk(clk), .rst(rst), .go(go), .key_in(key_in),
        .key_out(key_out), .key_valid(key_valid), .round(round), .last(last), .busy(busy)
    );

    aes128_dsp_keyfeed #(.INTERLEAVE(1)) dut1 (
        .clk(clk), .rst(rst), .go(go1), .key_in(key_in1),
        .key_out(key_out1), .key_valid(key_valid1), .round(round1), .last(last1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int cyc,
                               input logic [127:0] ak, input logic av, input logic [3:0] ar,
                               input logic al, input logic ab,
                               input logic [127:0] ek, input logic ev, input logic [3:0] er,
                               input logic el, input logic eb);
        total++;
        if (ak !== ek || av !== ev || ar !== er || al !== el || ab !== eb) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d got key=%h v=%b r=%0d l=%b b=%b want key=%h v=%b r=%0d l=%b b=%b",
                     tag, cyc, ak, av, ar, al, ab, ek, ev, er, el, eb);
        end
    endtask

    task automatic checkMain(input string tag, input int cyc, input logic [127:0] ek,
                             input logic ev, input logic [3:0] er, input logic el, input logic eb);
        checkOutput(tag, cyc, key_out, key_valid, round, last, busy, ek, ev, er, el, eb);
    endtask

    task automatic checkSched(input string tag, input int cyc, input logic [10:0][127:0] rk);
        int r;
        r = (cyc - 1) / IL;
        checkMain(tag, cyc, rk[r], 1'b1, 4'(r), (r == 10), 1'b1);
    endtask

    task automatic applyStimulus(input logic [127:0] k);
        key_in = k;
        go     = 1'b1;
        tick();
        go     = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        go      = 1'b0;
        key_in  = '0;
        go1     = 1'b0;
        key_in1 = '0;

        vec[0].key    = 128'h0;
        vec[0].rk[0]  = 128'h00000000000000000000000000000000;
        vec[0].rk[1]  = 128'h62636363626363636263636362636363;
        vec[0].rk[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
        vec[0].rk[3]  = 128'h90973450696ccffaf2f457330b0fac99;
        vec[0].rk[4]  = 128'hee06da7b876a1581759e42b27e91ee2b;
        vec[0].rk[5]  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
        vec[0].rk[6]  = 128'hec614b851425758c99ff09376ab49ba7;
        vec[0].rk[7]  = 128'h217517873550620bacaf6b3cc61bf09b;
        vec[0].rk[8]  = 128'h0ef903333ba9613897060a04511dfa9f;
        vec[0].rk[9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
        vec[0].rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        vec[1].key    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        vec[1].rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        vec[1].rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        vec[1].rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        vec[1].rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        vec[1].rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        vec[1].rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        vec[1].rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        vec[1].rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        vec[1].rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        vec[1].rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        vec[1].rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        ones_rk     = '0;
        ones_rk[0]  = {128{1'b1}};
        ones_rk[1]  = 128'he8e9e9e917161616e8e9e9e917161616;

        tick();
        tick();
        checkMain("reset", 0, 128'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        checkOutput("reset_il1", 0, key_out1, key_valid1, round1, last1, busy1,
                    128'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        checkMain("idle", 0, 128'h0, 1'b0, 4'd0, 1'b0, 1'b0);

        // INTERLEAVE=1: one key per cycle
        key_in1 = '0;
        go1     = 1'b1;
        tick();
        go1     = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            checkOutput("il1_sched", c, key_out1, key_valid1, round1, last1, busy1,
                        vec[0].rk[c-1], 1'b1, 4'(c - 1), (c == 11), 1'b1);
            tick();
        end
        checkOutput("il1_end", 12, key_out1, key_valid1, round1, last1, busy1,
                    128'h0, 1'b0, 4'd0, 1'b0, 1'b0);

        // table of full schedules, started back-to-back
        for (int v = 0; v < 2; v++) begin
            applyStimulus(vec[v].key);
            key_in = ~vec[v].key;
            for (int c = 1; c <= 11 * IL; c++) begin
                checkSched("sched", c, vec[v].rk);
                tick();
            end
            checkMain("sched_end", 11 * IL + 1, 128'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        end

        // GO while busy (including the final SK10 cycle) must be ignored
        applyStimulus(128'h0);
        for (int c = 1; c <= 11 * IL; c++) begin
            checkSched("busy_go", c, vec[0].rk);
            if (c == 5 || c == 50 || c == 11 * IL) begin
                go     = 1'b1;
                key_in = {128{1'b1}};
            end else begin
                go = 1'b0;
            end
            tick();
        end
        go = 1'b0;
        checkMain("busy_go_end", 11 * IL + 1, 128'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus({128{1'b1}});
        for (int c = 1; c <= IL + 1; c++) begin
            checkSched("ones_sched", c, ones_rk);
            tick();
        end

        // reset together with GO at cycle 40 of a run
        for (int c = IL + 2; c < 40; c++) tick();
        rst    = 1'b1;
        go     = 1'b1;
        key_in = vec[1].key;
        tick();
        rst = 1'b0;
        go  = 1'b0;
        checkMain("mid_reset", 41, 128'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        checkMain("post_reset_idle", 42, 128'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(vec[1].key);
        for (int c = 1; c <= IL + 1; c++) begin
            checkSched("restart", c, vec[1].rk);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
